// File: rtl/sfx_mem_seq.sv
// Load/store sequencer for the sfx core: splits one word request into sequential
// strobe/ack bus beats and returns a single assembled response.
module sfx_mem_seq #(
  parameter int ADDR_W     = 32,
  parameter int BUS_W      = 16,
  parameter int DATA_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int TIMEOUT    = 255,
  localparam int MAXB      = DATA_W / BUS_W,
  localparam int BEATS_W   = $clog2(MAXB) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  input  logic [BEATS_W-1:0] req_beats,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [DATA_W-1:0]  resp_rdata,
  output logic               resp_err,
  output logic               bus_cyc,
  output logic               bus_stb,
  output logic               bus_we,
  output logic [ADDR_W-1:0]  bus_addr,
  output logic [BUS_W-1:0]   bus_wdata,
  input  logic [BUS_W-1:0]   bus_rdata,
  input  logic               bus_ack,
  input  logic               bus_err,
  output logic [1:0]         addr_space
);

  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT,
    S_RESP
  } state_e;

  state_e               state_q, state_d;
  logic                 req_ready_q, req_ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]    resp_rdata_q, resp_rdata_d;
  logic                 resp_err_q, resp_err_d;
  logic                 bus_cyc_q, bus_cyc_d;
  logic                 bus_stb_q, bus_stb_d;
  logic                 bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]    bus_addr_q, bus_addr_d;
  logic [BUS_W-1:0]     bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [BEATS_W-1:0]   beats_q, beats_d;
  logic [BEATS_W-1:0]   beat_q, beat_d;
  logic [DATA_W-1:0]    acc_q, acc_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 timed_out;
  logic                 last_beat;
  logic                 beats_bad;

  // Write slice for beat k; big-endian sends the most-significant used slice first.
  function automatic logic [BUS_W-1:0] slice_for(input logic [DATA_W-1:0]  data,
                                                 input logic [BEATS_W-1:0] beats,
                                                 input logic [BEATS_W-1:0] k);
    logic [BEATS_W-1:0] idx;
    logic [DATA_W-1:0]  sh;
    idx = BIG_ENDIAN ? (beats - k - BEATS_W'(1)) : k;
    sh  = data >> (int'(idx) * BUS_W);
    return sh[BUS_W-1:0];
  endfunction

  assign timed_out = (TIMEOUT != 0) && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign last_beat = (beat_q == beats_q - BEATS_W'(1));
  assign beats_bad = (req_beats == '0) || (req_beats > BEATS_W'(MAXB));

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path infers a latch.
    state_d      = state_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    bus_cyc_d    = bus_cyc_q;
    bus_stb_d    = bus_stb_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    wdata_d      = wdata_q;
    beats_d      = beats_q;
    beat_d       = beat_q;
    acc_d        = acc_q;
    tmo_d        = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wdata_d      = req_wdata;
          beats_d      = req_beats;
          beat_d       = '0;
          acc_d        = '0;
          tmo_d        = '0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          if (beats_bad) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = S_BEAT;
            bus_cyc_d   = 1'b1;
            bus_stb_d   = 1'b1;
            bus_we_d    = req_we;
            bus_addr_d  = req_addr;
            bus_wdata_d = slice_for(req_wdata, req_beats, '0);
          end
        end
      end

      S_BEAT: begin
        tmo_d = tmo_q + TMO_W'(1);
        // Error wins over ack; a timeout is treated exactly like a bus error.
        if (bus_err || (timed_out && !bus_ack)) begin
          state_d      = S_RESP;
          bus_cyc_d    = 1'b0;
          bus_stb_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end else if (bus_ack) begin
          if (BIG_ENDIAN) begin
            acc_d = (acc_q << BUS_W) | DATA_W'(bus_rdata);
          end else begin
            acc_d[int'(beat_q) * BUS_W +: BUS_W] = bus_rdata;
          end
          if (last_beat) begin
            state_d      = S_RESP;
            bus_cyc_d    = 1'b0;
            bus_stb_d    = 1'b0;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = bus_we_q ? '0 : acc_d;
          end else begin
            beat_d      = beat_q + BEATS_W'(1);
            bus_addr_d  = bus_addr_q + ADDR_W'(BUS_W / 8);
            bus_wdata_d = slice_for(wdata_q, beats_q, beat_q + BEATS_W'(1));
            tmo_d       = '0;
          end
        end
      end

      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      bus_cyc_q    <= 1'b0;
      bus_stb_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      wdata_q      <= '0;
      beats_q      <= '0;
      beat_q       <= '0;
      acc_q        <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      bus_cyc_q    <= bus_cyc_d;
      bus_stb_q    <= bus_stb_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      wdata_q      <= wdata_d;
      beats_q      <= beats_d;
      beat_q       <= beat_d;
      acc_q        <= acc_d;
      tmo_q        <= tmo_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign bus_cyc    = bus_cyc_q;
  assign bus_stb    = bus_stb_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign addr_space = bus_addr_q[ADDR_W-1 -: 2];

endmodule

// File: tb/tb_sfx_mem_seq.sv
// Directed bench for sfx_mem_seq: a big-endian instance (TIMEOUT=4) with a configurable
// slave, plus a little-endian instance on a zero-wait slave.
module tb_sfx_mem_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Big-endian instance signals
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_beats = 2'd0;
  logic        req_ready, resp_valid, resp_err, bus_cyc, bus_stb, bus_we, bus_ack, bus_err;
  logic [31:0] resp_rdata, bus_addr;
  logic [15:0] bus_wdata, bus_rdata;
  logic [1:0]  addr_space;

  // Little-endian instance signals
  logic        le_req_valid = 1'b0, le_req_we = 1'b0;
  logic [31:0] le_req_addr = '0, le_req_wdata = '0;
  logic [1:0]  le_req_beats = 2'd0;
  logic        le_req_ready, le_resp_valid, le_resp_err, le_cyc, le_stb, le_we;
  logic [31:0] le_resp_rdata, le_addr;
  logic [15:0] le_wdata, le_rdata;
  logic [1:0]  le_space;

  // Configurable slave: s_wait wait states per beat, never-ack and error modes.
  int          s_wait = 0;
  bit          s_noack = 1'b0;
  bit          s_err_mode = 1'b0;
  int          s_cnt;
  logic [15:0] s_rd [0:3];

  always @(posedge clk or posedge rst) begin
    if (rst) s_cnt <= 0;
    else if (!bus_stb || bus_ack || bus_err) s_cnt <= 0;
    else s_cnt <= s_cnt + 1;
  end

  assign bus_err   = bus_stb && s_err_mode;
  assign bus_ack   = bus_stb && !s_noack && !s_err_mode && (s_cnt == s_wait);
  assign bus_rdata = s_rd[bus_addr[2:1]];
  assign le_rdata  = le_addr[1] ? 16'h5678 : 16'h1234;

  sfx_mem_seq #(.ADDR_W(32), .BUS_W(16), .DATA_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_beats(req_beats),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .addr_space(addr_space)
  );

  sfx_mem_seq #(.ADDR_W(32), .BUS_W(16), .DATA_W(32), .BIG_ENDIAN(1'b0), .TIMEOUT(255)) dut_le (
    .clk(clk), .rst(rst),
    .req_valid(le_req_valid), .req_ready(le_req_ready), .req_we(le_req_we), .req_addr(le_req_addr),
    .req_wdata(le_req_wdata), .req_beats(le_req_beats),
    .resp_valid(le_resp_valid), .resp_ready(1'b1), .resp_rdata(le_resp_rdata), .resp_err(le_resp_err),
    .bus_cyc(le_cyc), .bus_stb(le_stb), .bus_we(le_we), .bus_addr(le_addr),
    .bus_wdata(le_wdata), .bus_rdata(le_rdata), .bus_ack(le_stb), .bus_err(1'b0),
    .addr_space(le_space)
  );

  // Presents a request for one cycle; returns at the negedge of cycle 1 (after accept edge 0).
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] beats);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_beats = beats;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic issue_le(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] beats);
    @(negedge clk);
    le_req_valid = 1'b1; le_req_we = we; le_req_addr = addr; le_req_wdata = wdata; le_req_beats = beats;
    @(negedge clk);
    le_req_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
    checks++; if ({resp_valid, resp_err, bus_cyc, bus_stb, bus_we} !== 5'b0) begin errors++; $display("FAIL rst_ctrl: got %b expected 00000", {resp_valid, resp_err, bus_cyc, bus_stb, bus_we}); end
    checks++; if ({bus_addr, bus_wdata, resp_rdata, addr_space} !== 82'b0) begin errors++; $display("FAIL rst_data: got %h %h %h %b expected all 0", bus_addr, bus_wdata, resp_rdata, addr_space); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_read_be;
    issue(1'b0, 32'h4000_0000, 32'h0, 2'd2);
    checks++; if ({bus_cyc, bus_stb, bus_we, req_ready} !== 4'b1100) begin errors++; $display("FAIL rd_c1_ctrl: got %b expected 1100", {bus_cyc, bus_stb, bus_we, req_ready}); end
    checks++; if (bus_addr !== 32'h4000_0000) begin errors++; $display("FAIL rd_addr0: got %h expected 40000000", bus_addr); end
    checks++; if (addr_space !== 2'b01) begin errors++; $display("FAIL rd_space: got %b expected 01", addr_space); end
    @(negedge clk);
    checks++; if (bus_addr !== 32'h4000_0002 || bus_stb !== 1'b1) begin errors++; $display("FAIL rd_addr1: got %h stb %b expected 40000002 stb 1", bus_addr, bus_stb); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rd_early_valid: got %b expected 0", resp_valid); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || bus_cyc !== 1'b0) begin errors++; $display("FAIL rd_c3_resp: got v%b e%b cyc%b expected v1 e0 cyc0", resp_valid, resp_err, bus_cyc); end
    checks++; if (resp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_data: got %h expected 12345678", resp_rdata); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rd_c4_idle: got v%b rdy%b expected v0 rdy1", resp_valid, req_ready); end
  endtask

  task automatic test_write;
    issue(1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 2'd2);
    checks++; if (bus_wdata !== 16'hDEAD || bus_we !== 1'b1 || bus_addr !== 32'h1000_0000) begin errors++; $display("FAIL wr_beat0: got %h we%b @%h expected DEAD we1 @10000000", bus_wdata, bus_we, bus_addr); end
    @(negedge clk);
    checks++; if (bus_wdata !== 16'hBEEF || bus_we !== 1'b1 || bus_addr !== 32'h1000_0002) begin errors++; $display("FAIL wr_beat1: got %h we%b @%h expected BEEF we1 @10000002", bus_wdata, bus_we, bus_addr); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin errors++; $display("FAIL wr_resp: got v%b e%b %h expected v1 e0 00000000", resp_valid, resp_err, resp_rdata); end
    issue(1'b1, 32'h1000_0010, 32'h0000_BEEF, 2'd1);
    checks++; if (bus_wdata !== 16'hBEEF || bus_stb !== 1'b1) begin errors++; $display("FAIL wr1_beat: got %h stb%b expected BEEF stb1", bus_wdata, bus_stb); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || bus_cyc !== 1'b0) begin errors++; $display("FAIL wr1_resp: got v%b cyc%b expected v1 cyc0", resp_valid, bus_cyc); end
  endtask

  task automatic test_little_endian;
    issue_le(1'b1, 32'h0, 32'hDEAD_BEEF, 2'd2);
    checks++; if (le_wdata !== 16'hBEEF || le_stb !== 1'b1) begin errors++; $display("FAIL le_wr_beat0: got %h stb%b expected BEEF stb1", le_wdata, le_stb); end
    @(negedge clk);
    checks++; if (le_wdata !== 16'hDEAD) begin errors++; $display("FAIL le_wr_beat1: got %h expected DEAD", le_wdata); end
    @(negedge clk);
    checks++; if (le_resp_valid !== 1'b1 || le_resp_rdata !== 32'h0) begin errors++; $display("FAIL le_wr_resp: got v%b %h expected v1 00000000", le_resp_valid, le_resp_rdata); end
    issue_le(1'b0, 32'h0, 32'h0, 2'd2);
    repeat (2) @(negedge clk);
    checks++; if (le_resp_valid !== 1'b1 || le_resp_rdata !== 32'h5678_1234) begin errors++; $display("FAIL le_rd: got v%b %h expected v1 56781234", le_resp_valid, le_resp_rdata); end
  endtask

  task automatic test_wait_states;
    s_wait = 2;
    resp_ready = 1'b0;
    issue(1'b0, 32'h4000_0000, 32'h0, 2'd2);
    for (int c = 1; c <= 6; c++) begin
      checks++; if (bus_stb !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL ws_stb_c%0d: got stb%b v%b expected stb1 v0", c, bus_stb, resp_valid); end
      checks++; if (bus_addr !== ((c <= 3) ? 32'h4000_0000 : 32'h4000_0002)) begin errors++; $display("FAIL ws_addr_c%0d: got %h", c, bus_addr); end
      @(negedge clk);
    end
    for (int h = 0; h < 4; h++) begin
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h1234_5678 || req_ready !== 1'b0) begin errors++; $display("FAIL ws_hold_%0d: got v%b %h rdy%b expected v1 12345678 rdy0", h, resp_valid, resp_rdata, req_ready); end
      if (h == 3) resp_ready = 1'b1;
      @(negedge clk);
    end
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL ws_release: got v%b rdy%b expected v0 rdy1", resp_valid, req_ready); end
    s_wait = 0;
  endtask

  task automatic test_bus_err;
    s_err_mode = 1'b1;
    issue(1'b0, 32'h4000_0000, 32'h0, 2'd2);
    checks++; if (bus_stb !== 1'b1 || bus_addr !== 32'h4000_0000) begin errors++; $display("FAIL err_beat0: got stb%b @%h expected stb1 @40000000", bus_stb, bus_addr); end
    @(negedge clk);
    s_err_mode = 1'b0;
    checks++; if (bus_cyc !== 1'b0 || bus_stb !== 1'b0) begin errors++; $display("FAIL err_no_beat1: got cyc%b stb%b @%h expected cyc0 stb0", bus_cyc, bus_stb, bus_addr); end
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin errors++; $display("FAIL err_resp: got v%b e%b %h expected v1 e1 00000000", resp_valid, resp_err, resp_rdata); end
    issue(1'b0, 32'h4000_0000, 32'h0, 2'd2);
    repeat (2) @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL err_recover: got v%b e%b %h expected v1 e0 12345678", resp_valid, resp_err, resp_rdata); end
  endtask

  task automatic test_timeout;
    s_noack = 1'b1;
    issue(1'b0, 32'h4000_0000, 32'h0, 2'd2);
    for (int c = 1; c <= 4; c++) begin
      checks++; if (bus_stb !== 1'b1 || bus_cyc !== 1'b1) begin errors++; $display("FAIL tmo_stb_c%0d: got stb%b cyc%b expected 1 1", c, bus_stb, bus_cyc); end
      @(negedge clk);
    end
    s_noack = 1'b0;
    checks++; if (bus_cyc !== 1'b0 || bus_stb !== 1'b0) begin errors++; $display("FAIL tmo_drop: got cyc%b stb%b expected 0 0", bus_cyc, bus_stb); end
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin errors++; $display("FAIL tmo_resp: got v%b e%b %h expected v1 e1 00000000", resp_valid, resp_err, resp_rdata); end
  endtask

  task automatic test_illegal_beats;
    logic [1:0] bad [2];
    bad[0] = 2'd0;
    bad[1] = 2'd3;
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, 32'h4000_0000, 32'h0, bad[i]);
      checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || bus_cyc !== 1'b0 || resp_rdata !== 32'h0) begin errors++; $display("FAIL ill_beats%0d: got v%b e%b cyc%b %h expected v1 e1 cyc0 0", bad[i], resp_valid, resp_err, bus_cyc, resp_rdata); end
      @(negedge clk);
      checks++; if (bus_cyc !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL ill_after%0d: got cyc%b rdy%b expected cyc0 rdy1", bad[i], bus_cyc, req_ready); end
    end
  endtask

  task automatic test_addr_wrap;
    issue(1'b0, 32'hFFFF_FFFE, 32'h0, 2'd2);
    checks++; if (bus_addr !== 32'hFFFF_FFFE || addr_space !== 2'b11) begin errors++; $display("FAIL wrap_a0: got %h sp%b expected FFFFFFFE sp11", bus_addr, addr_space); end
    @(negedge clk);
    checks++; if (bus_addr !== 32'h0 || addr_space !== 2'b00) begin errors++; $display("FAIL wrap_a1: got %h sp%b expected 00000000 sp00", bus_addr, addr_space); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hAAAA_1234) begin errors++; $display("FAIL wrap_data: got v%b %h expected v1 AAAA1234", resp_valid, resp_rdata); end
  endtask

  task automatic test_reset_mid;
    s_wait = 2;
    issue(1'b0, 32'h4000_0000, 32'h0, 2'd2);
    repeat (3) @(negedge clk);
    checks++; if (bus_addr !== 32'h4000_0002 || bus_stb !== 1'b1) begin errors++; $display("FAIL rm_in_beat1: got %h stb%b expected 40000002 stb1", bus_addr, bus_stb); end
    rst = 1'b1;
    #1;
    checks++; if ({req_ready, resp_valid, resp_err, bus_cyc, bus_stb, bus_we} !== 6'b0) begin errors++; $display("FAIL rm_ctrl: got %b expected 000000", {req_ready, resp_valid, resp_err, bus_cyc, bus_stb, bus_we}); end
    checks++; if ({bus_addr, bus_wdata, resp_rdata, addr_space} !== 82'b0) begin errors++; $display("FAIL rm_data: got %h %h %h %b expected all 0", bus_addr, bus_wdata, resp_rdata, addr_space); end
    @(negedge clk);
    rst = 1'b0;
    s_wait = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0 || bus_cyc !== 1'b0) begin errors++; $display("FAIL rm_after_%0d: got v%b cyc%b expected v0 cyc0", c, resp_valid, bus_cyc); end
    end
  endtask

  initial begin
    s_rd[0] = 16'h1234;
    s_rd[1] = 16'h5678;
    s_rd[2] = 16'h9ABC;
    s_rd[3] = 16'hAAAA;
    test_reset();
    test_read_be();
    test_write();
    test_little_endian();
    test_wait_states();
    test_bus_err();
    test_timeout();
    test_illegal_beats();
    test_addr_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
